// File: rtl/riscv_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master between dBus (s0) and iBus (s1).
// Optional grant/stall counters are enabled with `define RD_ARB_PERF_CNT_EN.
module riscv_axi_rd_arbiter #(
    parameter int C_ADDR_WIDTH = 64,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [C_ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]              s0_arlen,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [C_DATA_WIDTH-1:0] s0_rdata,
    output logic                    s0_rlast,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [C_ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]              s1_arlen,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [C_DATA_WIDTH-1:0] s1_rdata,
    output logic                    s1_rlast,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [C_ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]              m_arlen,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [C_DATA_WIDTH-1:0] m_rdata,
    input  logic                    m_rlast,
`ifdef RD_ARB_PERF_CNT_EN
    output logic [31:0]             s0_grant_cnt,
    output logic [31:0]             s1_grant_cnt,
    output logic [31:0]             stall_cnt,
`endif
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   last_grant;
    logic   gnt0;
    logic   gnt1;
    logic   data_ph;

    // Tie goes to whichever requester did not win the previous grant
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE && ap_rst_n) begin
            if (s0_arvalid && (!s1_arvalid || last_grant))
                gnt0 = 1'b1;
            else if (s1_arvalid)
                gnt1 = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (gnt0 || gnt1) state_nxt = ADDR;
            ADDR: if (m_arready) state_nxt = DATA;
            DATA: if (m_rvalid && m_rready && m_rlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            m_araddr   <= '0;
            m_arlen    <= '0;
        end else begin
            state <= state_nxt;
            if (gnt0 || gnt1) begin
                owner      <= gnt1;
                last_grant <= gnt1;
                m_araddr   <= gnt1 ? s1_araddr : s0_araddr;
                m_arlen    <= gnt1 ? s1_arlen : s0_arlen;
            end
        end
    end

    assign s0_arready = gnt0;
    assign s1_arready = gnt1;
    assign m_arvalid  = (state == ADDR);
    assign busy       = (state != IDLE);
    assign data_ph    = (state == DATA);

    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign s0_rvalid = data_ph && !owner && m_rvalid;
    assign s1_rvalid = data_ph && owner && m_rvalid;
    assign s0_rlast  = data_ph && !owner && m_rlast;
    assign s1_rlast  = data_ph && owner && m_rlast;
    assign m_rready  = data_ph && (owner ? s1_rready : s0_rready);

`ifdef RD_ARB_PERF_CNT_EN
    logic [31:0] stall_inc;

    // Each waiting requester contributes one stall cycle
    assign stall_inc = 32'(s0_arvalid && !gnt0) + 32'(s1_arvalid && !gnt1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s0_grant_cnt <= '0;
            s1_grant_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (gnt0) s0_grant_cnt <= s0_grant_cnt + 32'd1;
            if (gnt1) s1_grant_cnt <= s1_grant_cnt + 32'd1;
            stall_cnt <= stall_cnt + stall_inc;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_axi_rd_arbiter.sv
// Self-checking bench for riscv_axi_rd_arbiter: arbitration table,
// directed corner sequences and a randomized run against a transaction model.
module tb_riscv_axi_rd_arbiter;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
    logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
    logic [63:0] s0_araddr, s1_araddr, m_araddr;
    logic [7:0]  s0_arlen, s1_arlen, m_arlen;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, busy;
`ifdef RD_ARB_PERF_CNT_EN
    logic [31:0] s0_grant_cnt, s1_grant_cnt, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ap_clk = ~ap_clk;

    riscv_axi_rd_arbiter #(
        .C_ADDR_WIDTH(64),
        .C_DATA_WIDTH(32)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s0_arvalid (s0_arvalid),
        .s0_arready (s0_arready),
        .s0_araddr  (s0_araddr),
        .s0_arlen   (s0_arlen),
        .s0_rvalid  (s0_rvalid),
        .s0_rready  (s0_rready),
        .s0_rdata   (s0_rdata),
        .s0_rlast   (s0_rlast),
        .s1_arvalid (s1_arvalid),
        .s1_arready (s1_arready),
        .s1_araddr  (s1_araddr),
        .s1_arlen   (s1_arlen),
        .s1_rvalid  (s1_rvalid),
        .s1_rready  (s1_rready),
        .s1_rdata   (s1_rdata),
        .s1_rlast   (s1_rlast),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .m_rlast    (m_rlast),
`ifdef RD_ARB_PERF_CNT_EN
        .s0_grant_cnt(s0_grant_cnt),
        .s1_grant_cnt(s1_grant_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // One single-beat burst; w is the requester the arbiter must pick.
    task automatic run_vec(input bit v0, input bit v1, input bit w,
                           input int idx);
        logic [63:0] a0, a1, wa;
        logic [31:0] d;
        a0 = 64'h0000_0001_0000_0000 + 64'(idx) * 64'h40;
        a1 = 64'h0000_0002_0000_0000 + 64'(idx) * 64'h40;
        wa = w ? a1 : a0;
        d  = 32'hC0DE_0000 + 32'(idx);
        s0_arvalid = v0; s0_araddr = a0; s0_arlen = 8'd0;
        s1_arvalid = v1; s1_araddr = a1; s1_arlen = 8'd0;
        @(negedge ap_clk);
        chk($sformatf("v%0d_ar0", idx), s0_arready, !w);
        chk($sformatf("v%0d_ar1", idx), s1_arready, w);
        step();
        s0_arvalid = 0; s1_arvalid = 0;
        @(negedge ap_clk);
        chk($sformatf("v%0d_arv", idx), m_arvalid, 1);
        chk($sformatf("v%0d_addr", idx), m_araddr, wa);
        chk($sformatf("v%0d_len", idx), m_arlen, 0);
        m_arready = 1;
        step();
        m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = d;
        s0_rready = 1; s1_rready = 1;
        @(negedge ap_clk);
        chk($sformatf("v%0d_rv0", idx), s0_rvalid, !w);
        chk($sformatf("v%0d_rv1", idx), s1_rvalid, w);
        chk($sformatf("v%0d_rdat", idx), w ? s1_rdata : s0_rdata, d);
        chk($sformatf("v%0d_mrr", idx), m_rready, 1);
        step();
        m_rvalid = 0; m_rlast = 0;
        @(negedge ap_clk);
        chk($sformatf("v%0d_idle", idx), busy, 0);
        step();
    endtask

    typedef struct {
        bit v0;
        bit v1;
        bit w;
    } vec_t;

    vec_t tbl[9];

    // Random-phase model
    int          ph;
    bit          prev, own, any, w;
    bit          rv[2], rr[2];
    logic [63:0] ra[2];
    logic [7:0]  rl[2];
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;
    logic [31:0] exp_q[$];
    bit          sl_act;
    logic [63:0] sl_addr;
    logic [7:0]  sl_len, sl_idx;
    int          ngr[2];
    int          nstall;

    initial begin
        tbl[0] = '{1, 1, 0}; tbl[1] = '{1, 1, 1}; tbl[2] = '{1, 1, 0};
        tbl[3] = '{1, 0, 0}; tbl[4] = '{1, 1, 1}; tbl[5] = '{0, 1, 1};
        tbl[6] = '{1, 1, 0}; tbl[7] = '{0, 1, 1}; tbl[8] = '{1, 1, 0};

        ap_rst_n = 0;
        s0_arvalid = 1; s0_araddr = 64'h55; s0_arlen = 8'd9; s0_rready = 0;
        s1_arvalid = 1; s1_araddr = 64'h66; s1_arlen = 8'd9; s1_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rlast = 0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_busy", busy, 0);
        chk("rst_arv", m_arvalid, 0);
        chk("rst_addr", m_araddr, 0);
        chk("rst_len", m_arlen, 0);
        chk("rst_ar0", s0_arready, 0);
        chk("rst_ar1", s1_arready, 0);
        s0_arvalid = 0; s1_arvalid = 0;
        step();
        ap_rst_n = 1;
        step();

        for (int i = 0; i < 9; i++)
            run_vec(tbl[i].v0, tbl[i].v1, tbl[i].w, i);

        // Held-off AR channel, 4-beat s0 burst, s1 waiting behind it
        s0_arvalid = 1; s0_araddr = 64'h1000; s0_arlen = 8'd3;
        @(negedge ap_clk);
        chk("st_gnt0", s0_arready, 1);
        step();
        s0_arvalid = 0;
        s1_arvalid = 1; s1_araddr = 64'h2000; s1_arlen = 8'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            chk($sformatf("st_arv%0d", c), m_arvalid, 1);
            chk($sformatf("st_addr%0d", c), m_araddr, 64'h1000);
            chk($sformatf("st_len%0d", c), m_arlen, 3);
            chk($sformatf("st_ar1_%0d", c), s1_arready, 0);
            step();
        end
        m_arready = 1;
        step();
        m_arready = 0; s0_rready = 1; m_rvalid = 1;
        for (int b = 0; b < 4; b++) begin
            m_rdata = 32'hA0 + 32'(b); m_rlast = (b == 3);
            @(negedge ap_clk);
            chk($sformatf("st_rv0_%0d", b), s0_rvalid, 1);
            chk($sformatf("st_rd0_%0d", b), s0_rdata, 32'hA0 + 32'(b));
            chk($sformatf("st_rl0_%0d", b), s0_rlast, b == 3);
            chk($sformatf("st_rv1_%0d", b), s1_rvalid, 0);
            chk($sformatf("st_gw_%0d", b), s1_arready, 0);
            step();
        end
        m_rvalid = 0; m_rlast = 0;
        @(negedge ap_clk);
        chk("st_gnt1", s1_arready, 1);
        step();
        s1_arvalid = 0;
        @(negedge ap_clk);
        chk("st_addr1", m_araddr, 64'h2000);
        m_arready = 1;
        step();
        m_arready = 0; m_rvalid = 1; m_rlast = 1; s1_rready = 1;
        @(negedge ap_clk);
        chk("st_rv1", s1_rvalid, 1);
        chk("st_rl1", s1_rlast, 1);
        step();
        m_rvalid = 0; m_rlast = 0;

        // Reset during the third beat of a 4-beat burst
        s0_arvalid = 1; s0_araddr = 64'h3000; s0_arlen = 8'd3;
        step();
        s0_arvalid = 0; m_arready = 1;
        step();
        m_arready = 0; m_rvalid = 1; m_rlast = 0;
        step();
        step();
        @(negedge ap_clk);
        ap_rst_n = 0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_arv", m_arvalid, 0);
        chk("mr_rrdy", m_rready, 0);
        chk("mr_rv0", s0_rvalid, 0);
        m_rvalid = 0;
        step();
        ap_rst_n = 1;
        step();
        run_vec(1, 0, 0, 20);

        // Randomized traffic against the transaction model
        ph = 0; prev = 0; own = 0; sl_act = 0;
        rv[0] = 0; rv[1] = 0; ngr[0] = 0; ngr[1] = 0; nstall = 0;
`ifdef RD_ARB_PERF_CNT_EN
        begin
            logic [31:0] b0, b1, bs;
            b0 = s0_grant_cnt; b1 = s1_grant_cnt; bs = stall_cnt;
`endif
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1;
                    ra[i] = {$urandom, $urandom} & ~64'h3;
                    rl[i] = 8'($urandom_range(0, 3));
                end
                rr[i] = ($urandom_range(0, 3) != 0);
            end
            m_arready = 1'($urandom_range(0, 1));
            if (sl_act) begin
                m_rvalid = ($urandom_range(0, 3) != 0);
                m_rdata  = sl_addr[31:0] + 32'(sl_idx);
                m_rlast  = (sl_idx == sl_len);
            end else begin
                m_rvalid = ($urandom_range(0, 4) == 0);
                m_rdata  = $urandom;
                m_rlast  = 1'($urandom_range(0, 1));
            end
            s0_arvalid = rv[0]; s0_araddr = ra[0]; s0_arlen = rl[0];
            s1_arvalid = rv[1]; s1_araddr = ra[1]; s1_arlen = rl[1];
            s0_rready = rr[0]; s1_rready = rr[1];
            @(negedge ap_clk);

            any = (ph == 0) && (rv[0] || rv[1]);
            w   = (rv[0] && rv[1]) ? !prev : rv[1];
            chk("r_ar0", s0_arready, any && !w);
            chk("r_ar1", s1_arready, any && w);
            chk("r_busy", busy, ph != 0);
            chk("r_arv", m_arvalid, ph == 1);
            if (ph == 1) begin
                chk("r_addr", m_araddr, exp_addr);
                chk("r_len", m_arlen, exp_len);
            end
            if (ph == 2) begin
                chk("r_rv0", s0_rvalid, !own && m_rvalid);
                chk("r_rv1", s1_rvalid, own && m_rvalid);
                chk("r_mrr", m_rready, rr[own]);
                if (m_rvalid && rr[own]) begin
                    if (exp_q.size() == 0) begin
                        chk("r_extra", 1, 0);
                    end else begin
                        chk("r_rdat", own ? s1_rdata : s0_rdata, exp_q[0]);
                        chk("r_rlast", own ? s1_rlast : s0_rlast,
                            exp_q.size() == 1);
                    end
                end
            end else begin
                chk("r_mrr0", m_rready, 0);
                chk("r_rvx0", s0_rvalid, 0);
                chk("r_rvx1", s1_rvalid, 0);
            end

            nstall += int'(rv[0] && !(any && !w)) + int'(rv[1] && !(any && w));
            if (any) begin
                ph = 1; prev = w; own = w;
                exp_addr = ra[w]; exp_len = rl[w];
                exp_q.delete();
                for (int b = 0; b <= int'(rl[w]); b++)
                    exp_q.push_back(ra[w][31:0] + 32'(b));
                rv[w] = 0;
                ngr[w]++;
            end else if (ph == 1 && m_arready) begin
                ph = 2; sl_act = 1;
                sl_addr = m_araddr; sl_len = m_arlen; sl_idx = 0;
            end else if (ph == 2 && m_rvalid && rr[own]) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (sl_act) begin
                    if (sl_idx == sl_len) sl_act = 0;
                    else sl_idx++;
                end
                if (m_rlast) ph = 0;
            end
            step();
        end
`ifdef RD_ARB_PERF_CNT_EN
            chk("pc_s0", s0_grant_cnt - b0, 32'(ngr[0]));
            chk("pc_s1", s1_grant_cnt - b1, 32'(ngr[1]));
            chk("pc_stall", stall_cnt - bs, 32'(nstall));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
